// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Holds the FSM state enum and the wait-counter sizing helpers.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam int DEF_TIMEOUT = 255;

  function automatic int wait_w(input int t);
    return $clog2(t + 1);
  endfunction

  localparam int DEF_WAIT_W = wait_w(DEF_TIMEOUT);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
// Increments by one per enabled cycle and holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // count up on inc, stop at the maximum value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline freeze/flush sequencing with memory-wait watchdog.
// Perf counters built only with PIPE_HAZARD_CTRL_PERF_EN defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branchTaken,
  input  logic             memReq,
  input  logic             memReady,
  output logic             pcFreeze,
  output logic             ifidFreeze,
  output logic             ifidFlush,
  output logic             idexFlush,
  output logic             stallAll,
  output logic             memAbort,
  output logic             errTimeout,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount,
  output logic [CNT_W-1:0] hazardCycles
);

  localparam int WW = wait_w(TIMEOUT);
  localparam logic [WW-1:0] LAST = WW'(TIMEOUT - 1);

  state_t state;
  state_t state_d;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] cnt_d;
  logic timeout_hit;
  logic mem_stall;
  logic br_win;
  logic hz_win;

  assign timeout_hit = (state == MEM_WAIT) && (wait_cnt == LAST);

  // mutually exclusive winners of the priority chain, gated by reset
  assign mem_stall = rst & memReq & ~memReady & ~timeout_hit;
  assign br_win    = rst & ~mem_stall & branchTaken;
  assign hz_win    = rst & ~mem_stall & ~branchTaken & hazard;

  // state and wait counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= cnt_d;
    end
  end

  // sticky watchdog error, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      errTimeout <= 1'b0;
    end else if (timeout_hit) begin
      errTimeout <= 1'b1;
    end
  end

  // next state and wait count
  always_comb begin
    state_d = state;
    cnt_d   = '0;
    unique case (state)
      RUN: begin
        if (memReq && !memReady) begin
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (memReady || !memReq || timeout_hit) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (state == MEM_WAIT && state_d == MEM_WAIT) begin
      cnt_d = wait_cnt + WW'(1);
    end
  end

  // Mealy pipeline controls from the priority chain
  always_comb begin
    pcFreeze   = 1'b0;
    ifidFreeze = 1'b0;
    ifidFlush  = 1'b0;
    idexFlush  = 1'b0;
    stallAll   = 1'b0;
    unique case (1'b1)
      mem_stall: begin
        stallAll   = 1'b1;
        pcFreeze   = 1'b1;
        ifidFreeze = 1'b1;
      end
      br_win: begin
        ifidFlush = 1'b1;
        idexFlush = 1'b1;
      end
      hz_win: begin
        pcFreeze   = 1'b1;
        ifidFreeze = 1'b1;
        idexFlush  = 1'b1;
      end
      default: ;
    endcase
  end

  assign memAbort = rst & timeout_hit;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  sat_counter #(.W(CNT_W)) u_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (stallAll),
    .count (stallCycles)
  );

  sat_counter #(.W(CNT_W)) u_flush (
    .clk   (clk),
    .rst   (rst),
    .inc   (ifidFlush),
    .count (flushCount)
  );

  sat_counter #(.W(CNT_W)) u_hazard (
    .clk   (clk),
    .rst   (rst),
    .inc   (hz_win),
    .count (hazardCycles)
  );
`else
  assign stallCycles  = '0;
  assign flushCount   = '0;
  assign hazardCycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with TIMEOUT=4.
// Counter expectations collapse to 0 without PIPE_HAZARD_CTRL_PERF_EN.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  logic hazard, branchTaken, memReq, memReady;
  logic pcFreeze, ifidFreeze, ifidFlush, idexFlush;
  logic stallAll, memAbort, errTimeout;
  logic [CW-1:0] stallCycles, flushCount, hazardCycles;
  logic [6:0] ctl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .hazard       (hazard),
    .branchTaken  (branchTaken),
    .memReq       (memReq),
    .memReady     (memReady),
    .pcFreeze     (pcFreeze),
    .ifidFreeze   (ifidFreeze),
    .ifidFlush    (ifidFlush),
    .idexFlush    (idexFlush),
    .stallAll     (stallAll),
    .memAbort     (memAbort),
    .errTimeout   (errTimeout),
    .stallCycles  (stallCycles),
    .flushCount   (flushCount),
    .hazardCycles (hazardCycles)
  );

  // {pcF, ifidFrz, ifidFl, idexFl, stall, abort, err}
  assign ctl = {pcFreeze, ifidFreeze, ifidFlush, idexFlush,
                stallAll, memAbort, errTimeout};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pv(input int v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  task automatic cnts(input string tag, input int s, input int f,
                      input int h);
    chk({tag, ".stall"}, 32'(stallCycles), pv(s));
    chk({tag, ".flush"}, 32'(flushCount), pv(f));
    chk({tag, ".haz"}, 32'(hazardCycles), pv(h));
  endtask

  initial begin
    rst = 1'b0;
    hazard = 1'b1;
    branchTaken = 1'b1;
    memReq = 1'b1;
    memReady = 1'b1;
    #3;
    chk("rst.ctl0", 32'(ctl), 32'h0);
    cnts("rst0", 0, 0, 0);
    memReady = 1'b0;
    #1;
    chk("rst.ctl1", 32'(ctl), 32'h0);
    cyc();
    cyc();
    chk("rst.ctl2", 32'(ctl), 32'h0);
    cnts("rst2", 0, 0, 0);

    hazard = 1'b0;
    branchTaken = 1'b0;
    memReq = 1'b0;
    memReady = 1'b0;
    rst = 1'b1;
    #1;
    chk("idle", 32'(ctl), 32'h0);
    cyc();

    hazard = 1'b1;
    #1;
    chk("haz", 32'(ctl), 32'b1101000);
    cyc();
    hazard = 1'b0;
    cnts("haz", 0, 0, 1);

    hazard = 1'b1;
    branchTaken = 1'b1;
    #1;
    chk("brhaz", 32'(ctl), 32'b0011000);
    cyc();
    hazard = 1'b0;
    branchTaken = 1'b0;
    cnts("brhaz", 0, 1, 1);

    memReq = 1'b1;
    branchTaken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mem.w%0d", i), 32'(ctl), 32'b1100100);
      cyc();
    end
    memReady = 1'b1;
    #1;
    chk("mem.rdy", 32'(ctl), 32'b0011000);
    cyc();
    memReq = 1'b0;
    memReady = 1'b0;
    branchTaken = 1'b0;
    #1;
    chk("mem.done", 32'(ctl), 32'h0);
    cnts("mem", 3, 2, 1);

    memReq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("to.w%0d", i), 32'(ctl), 32'b1100100);
      cyc();
    end
    #1;
    chk("to.abort", 32'(ctl), 32'b0000010);
    cyc();
    memReq = 1'b0;
    #1;
    chk("to.err", 32'(ctl), 32'b0000001);
    cyc();
    cyc();
    chk("to.sticky", 32'(ctl), 32'b0000001);
    cnts("to", 7, 2, 1);

    memReq = 1'b1;
    cyc();
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("rmw.ctl", 32'(ctl), 32'h0);
    cnts("rmw", 0, 0, 0);
    cyc();
    chk("rmw.hold", 32'(ctl), 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rmw.w%0d", i), 32'(ctl), 32'b1100100);
      cyc();
    end
    #1;
    chk("rmw.abort", 32'(ctl), 32'b0000010);
    cyc();
    memReq = 1'b0;
    #1;
    chk("rmw.err", 32'(ctl), 32'b0000001);
    cnts("rmw.end", 4, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
